// File: rtl/data_memory_arbiter_if.sv
// Two-requester data memory bus: requester-side handshakes
// plus the single-ported memory side.
interface data_memory_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  p0_req;
    logic                  p0_we;
    logic [ADDR_WIDTH-1:0] p0_addr;
    logic [DATA_WIDTH-1:0] p0_wdata;
    logic                  p0_ready;
    logic                  p0_rvalid;
    logic [DATA_WIDTH-1:0] p0_rdata;

    logic                  p1_req;
    logic                  p1_we;
    logic [ADDR_WIDTH-1:0] p1_addr;
    logic [DATA_WIDTH-1:0] p1_wdata;
    logic                  p1_ready;
    logic                  p1_rvalid;
    logic [DATA_WIDTH-1:0] p1_rdata;

    logic                  mem_write_enable;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic [DATA_WIDTH-1:0] mem_read_data;

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_read_data,
        input  p0_ready, p0_rvalid, p0_rdata,
        input  p1_ready, p1_rvalid, p1_rdata,
        input  mem_write_enable, mem_address, mem_write_data
    );

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_read_data,
        output p0_ready, p0_rvalid, p0_rdata,
        output p1_ready, p1_rvalid, p1_rdata,
        output mem_write_enable, mem_address, mem_write_data
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one data memory between two ports;
// one access per two cycles, completion pulsed the cycle after access.
module data_memory_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input logic                  system_clock,
    input logic                  reset_n,
    data_memory_arbiter_if.slave bus
);
    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  last_grant_q;
    logic                  grant_p1;
    logic                  accept;
    logic                  ready0;
    logic                  ready1;

    logic                  req_we_q;
    logic                  req_port_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [DATA_WIDTH-1:0] req_wdata_q;

    logic                  rvalid0_q;
    logic                  rvalid1_q;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;
    logic                  active;

    always_comb begin
        state_d  = state_q;
        grant_p1 = 1'b0;
        accept   = 1'b0;
        ready0   = 1'b0;
        ready1   = 1'b0;
        // On a tie the port that did not win last time goes first
        if (bus.p0_req && bus.p1_req)
            grant_p1 = ~last_grant_q;
        else
            grant_p1 = bus.p1_req;
        unique case (state_q)
            IDLE: begin
                accept = reset_n && (bus.p0_req || bus.p1_req);
                ready0 = accept && !grant_p1;
                ready1 = accept && grant_p1;
                if (accept)
                    state_d = ACCESS;
            end
            ACCESS: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge system_clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            req_we_q     <= 1'b0;
            req_port_q   <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q   <= state_d;
            rvalid0_q <= (state_q == ACCESS) && !req_port_q;
            rvalid1_q <= (state_q == ACCESS) && req_port_q;
            if (accept) begin
                last_grant_q <= grant_p1;
                req_port_q   <= grant_p1;
                req_we_q     <= grant_p1 ? bus.p1_we : bus.p0_we;
                req_addr_q   <= grant_p1 ? bus.p1_addr : bus.p0_addr;
                req_wdata_q  <= grant_p1 ? bus.p1_wdata : bus.p0_wdata;
            end
            if (state_q == ACCESS && !req_we_q) begin
                if (req_port_q)
                    rdata1_q <= bus.mem_read_data;
                else
                    rdata0_q <= bus.mem_read_data;
            end
        end
    end

    // reset_n gating keeps an in-flight write from committing
    assign active = (state_q == ACCESS) && reset_n;

    assign bus.mem_write_enable = active && req_we_q;
    assign bus.mem_address      = active ? req_addr_q : '0;
    assign bus.mem_write_data   = active ? req_wdata_q : '0;

    assign bus.p0_ready  = ready0;
    assign bus.p1_ready  = ready1;
    assign bus.p0_rvalid = rvalid0_q && reset_n;
    assign bus.p1_rvalid = rvalid1_q && reset_n;
    assign bus.p0_rdata  = rdata0_q;
    assign bus.p1_rdata  = rdata1_q;
endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed-vector bench for the two-port data memory arbiter.
module tb_data_memory_arbiter;
    logic system_clock = 1'b0;
    logic reset_n      = 1'b0;
    int   checks       = 0;
    int   errors       = 0;

    data_memory_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    data_memory_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .system_clock (system_clock),
        .reset_n      (reset_n),
        .bus          (bus.slave)
    );

    always #5 system_clock = ~system_clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge system_clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = 0; bus.p0_wdata = 0;
        bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = 0; bus.p1_wdata = 0;
        bus.mem_read_data = 0;

        // Reset: outputs quiet even with a pending request
        tick(); tick();
        bus.p0_req = 1;
        settle();
        chk("rst_p0_ready", bus.p0_ready, 0);
        chk("rst_p0_rvalid", bus.p0_rvalid, 0);
        chk("rst_mem_we", bus.mem_write_enable, 0);
        chk("rst_mem_addr", bus.mem_address, 0);
        chk("rst_p0_rdata", bus.p0_rdata, 0);
        chk("rst_p1_rdata", bus.p1_rdata, 0);
        bus.p0_req = 0;
        tick();
        reset_n = 1;

        // Single read on p0
        tick();
        bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 32'h10;
        bus.mem_read_data = 32'hDEADBEEF;
        settle();
        chk("rd_p0_ready", bus.p0_ready, 1);
        chk("rd_p1_ready", bus.p1_ready, 0);
        chk("rd_idle_addr", bus.mem_address, 0);
        tick();
        bus.p0_req = 0;
        settle();
        chk("rd_mem_addr", bus.mem_address, 32'h10);
        chk("rd_mem_we", bus.mem_write_enable, 0);
        chk("rd_access_ready", bus.p0_ready, 0);
        chk("rd_access_rvalid", bus.p0_rvalid, 0);
        tick();
        chk("rd_rvalid", bus.p0_rvalid, 1);
        chk("rd_rdata", bus.p0_rdata, 32'hDEADBEEF);
        chk("rd_p1_rvalid", bus.p1_rvalid, 0);
        chk("rd_post_addr", bus.mem_address, 0);
        tick();
        chk("rd_rvalid_drop", bus.p0_rvalid, 0);
        chk("rd_rdata_hold", bus.p0_rdata, 32'hDEADBEEF);

        // Write on p1; rdata must not capture the memory bus
        bus.p1_req = 1; bus.p1_we = 1; bus.p1_addr = 32'h20;
        bus.p1_wdata = 32'h12345678;
        bus.mem_read_data = 32'h55AA55AA;
        settle();
        chk("wr_p1_ready", bus.p1_ready, 1);
        chk("wr_p0_ready", bus.p0_ready, 0);
        chk("wr_idle_we", bus.mem_write_enable, 0);
        tick();
        bus.p1_req = 0;
        settle();
        chk("wr_mem_we", bus.mem_write_enable, 1);
        chk("wr_mem_addr", bus.mem_address, 32'h20);
        chk("wr_mem_wdata", bus.mem_write_data, 32'h12345678);
        tick();
        chk("wr_we_drop", bus.mem_write_enable, 0);
        chk("wr_wdata_idle", bus.mem_write_data, 0);
        chk("wr_rvalid", bus.p1_rvalid, 1);
        chk("wr_p0_rvalid", bus.p0_rvalid, 0);
        chk("wr_rdata_keep", bus.p1_rdata, 0);
        tick();

        // Back-to-back reads on p0
        bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 32'h40;
        bus.mem_read_data = 32'hA5A50001;
        settle();
        chk("b2b_ready1", bus.p0_ready, 1);
        tick();
        bus.p0_addr = 32'h44;
        settle();
        chk("b2b_access_ready", bus.p0_ready, 0);
        chk("b2b_addr1", bus.mem_address, 32'h40);
        tick();
        chk("b2b_rvalid1", bus.p0_rvalid, 1);
        chk("b2b_ready2", bus.p0_ready, 1);
        chk("b2b_rdata1", bus.p0_rdata, 32'hA5A50001);
        bus.mem_read_data = 32'hA5A50002;
        tick();
        bus.p0_req = 0;
        settle();
        chk("b2b_addr2", bus.mem_address, 32'h44);
        chk("b2b_mid_rvalid", bus.p0_rvalid, 0);
        tick();
        chk("b2b_rvalid2", bus.p0_rvalid, 1);
        chk("b2b_rdata2", bus.p0_rdata, 32'hA5A50002);

        // Contention straight after reset: p0 wins first tie
        reset_n = 0;
        tick();
        chk("ct_rst_rdata", bus.p0_rdata, 0);
        reset_n = 1;
        bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 32'h100;
        bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 32'h200;
        bus.mem_read_data = 32'h0BADF00D;
        settle();
        for (int i = 0; i < 8; i++) begin
            logic e0;
            logic e1;
            e0 = (i % 4) == 0;
            e1 = (i % 4) == 2;
            chk($sformatf("ct_p0_ready_%0d", i), bus.p0_ready, e0);
            chk($sformatf("ct_p1_ready_%0d", i), bus.p1_ready, e1);
            tick();
        end
        bus.p0_req = 0; bus.p1_req = 0;
        tick();
        chk("ct_p0_rdata", bus.p0_rdata, 32'h0BADF00D);
        chk("ct_p1_rdata", bus.p1_rdata, 32'h0BADF00D);

        // Reset while a p0 write is in ACCESS
        bus.p0_req = 1; bus.p0_we = 1; bus.p0_addr = 32'h80;
        bus.p0_wdata = 32'hCAFEF00D;
        settle();
        chk("mr_ready", bus.p0_ready, 1);
        tick();
        bus.p0_req = 0;
        settle();
        chk("mr_we_pre", bus.mem_write_enable, 1);
        reset_n = 0;
        settle();
        chk("mr_we_gated", bus.mem_write_enable, 0);
        chk("mr_addr_gated", bus.mem_address, 0);
        chk("mr_wdata_gated", bus.mem_write_data, 0);
        tick();
        chk("mr_no_rvalid", bus.p0_rvalid, 0);
        chk("mr_rdata0", bus.p0_rdata, 0);
        chk("mr_rdata1", bus.p1_rdata, 0);
        reset_n = 1;
        tick();
        chk("mr_no_rvalid2", bus.p0_rvalid, 0);
        chk("mr_idle_we", bus.mem_write_enable, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
